// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle for decode_stage.
//   slave  : the decode stage's view (fetch-side inputs, decoded outputs).
//   master : the surrounding pipeline's view.
// Fetch side   : i_Valid / o_Ready, i_InstructionWord, i_PC, i_Flush.
// Execute side : o_Valid / i_Ready plus the decoded control bundle.
// XLEN and REG_ADDR_WIDTH must match the decode_stage instance they connect to.
interface decode_stage_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      i_Valid;
  logic                      o_Ready;
  logic [31:0]               i_InstructionWord;
  logic [XLEN-1:0]           i_PC;
  logic                      i_Flush;
  logic                      o_Valid;
  logic                      i_Ready;
  logic [XLEN-1:0]           o_PC;
  logic [REG_ADDR_WIDTH-1:0] o_rs1;
  logic [REG_ADDR_WIDTH-1:0] o_rs2;
  logic [REG_ADDR_WIDTH-1:0] o_rd;
  logic [2:0]                o_Function;
  logic [2:0]                o_AluOp;
  logic                      o_AluOpAlt;
  logic [1:0]                o_AluSrc1;
  logic [1:0]                o_AluSrc2;
  logic                      o_WritebackSrc;
  logic                      o_RegWrite;
  logic                      o_MemRead;
  logic                      o_MemWrite;
  logic                      o_Jump;
  logic                      o_Branch;
  logic                      o_JALR;
  logic                      o_MulDiv;
  logic                      o_EnvCall;
  logic                      o_EnvBreak;
  logic                      o_IllegalInstruction;
  logic [XLEN-1:0]           o_Immediate;

  modport slave (
    input  i_Valid, i_InstructionWord, i_PC, i_Flush, i_Ready,
    output o_Ready, o_Valid, o_PC, o_rs1, o_rs2, o_rd, o_Function, o_AluOp,
           o_AluOpAlt, o_AluSrc1, o_AluSrc2, o_WritebackSrc, o_RegWrite,
           o_MemRead, o_MemWrite, o_Jump, o_Branch, o_JALR, o_MulDiv,
           o_EnvCall, o_EnvBreak, o_IllegalInstruction, o_Immediate
  );

  modport master (
    output i_Valid, i_InstructionWord, i_PC, i_Flush, i_Ready,
    input  o_Ready, o_Valid, o_PC, o_rs1, o_rs2, o_rd, o_Function, o_AluOp,
           o_AluOpAlt, o_AluSrc1, o_AluSrc2, o_WritebackSrc, o_RegWrite,
           o_MemRead, o_MemWrite, o_Jump, o_Branch, o_JALR, o_MulDiv,
           o_EnvCall, o_EnvBreak, o_IllegalInstruction, o_Immediate
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/E instruction decode between fetch and execute.
// Ports:
//   i_Clock   rising-edge clock
//   i_Reset_n asynchronous active-low reset; every output register clears
//   bus       decode_stage_if.slave (fetch valid/ready in, decoded bundle out)
// One cycle from an accepted instruction to o_Valid. A load whose rd is read
// by the next instruction costs one bubble; i_Flush drops both the held and
// the incoming instruction.
package decode_stage_pkg;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] ALUSRC1_RS1  = 2'd0;
  localparam logic [1:0] ALUSRC1_PC   = 2'd1;
  localparam logic [1:0] ALUSRC1_ZERO = 2'd2;
  localparam logic [1:0] ALUSRC2_RS2  = 2'd0;
  localparam logic [1:0] ALUSRC2_IMM  = 2'd1;
  localparam logic [1:0] ALUSRC2_FOUR = 2'd2;
  localparam logic       WBSRC_ALU    = 1'b0;
  localparam logic       WBSRC_MEM    = 1'b1;
  // ALU operation codes follow funct3 so OP/OP_IMM pass it straight through.
  localparam logic [2:0] ALUOP_ADD    = 3'b000;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_op_alt;
    logic [1:0] alu_src1;
    logic [1:0] alu_src2;
    logic       wb_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic       mul_div;
    logic       env_call;
    logic       env_break;
    logic       illegal;
  } ctrl_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ENABLE_M       = 0
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  decode_stage_if.slave bus
);
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        use_rs1, use_rs2, use_rd;
  ctrl_t       ctrl_d, ctrl_q;

  logic                      valid_q;
  logic [XLEN-1:0]           pc_q, imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]                funct3_q;
  logic                      adv, hz, accept;

  assign instr  = bus.i_InstructionWord;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.alu_op   = ALUOP_ADD;
    ctrl_d.alu_src1 = ALUSRC1_RS1;
    ctrl_d.alu_src2 = ALUSRC2_RS2;
    ctrl_d.wb_src   = WBSRC_ALU;
    imm32           = '0;
    use_rs1         = 1'b0;
    use_rs2         = 1'b0;
    use_rd          = 1'b0;
    ctrl_d.illegal  = (instr[1:0] != 2'b11);
    case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1; ctrl_d.reg_write = 1'b1; imm32 = imm_u;
        ctrl_d.alu_src1 = ALUSRC1_ZERO; ctrl_d.alu_src2 = ALUSRC2_IMM;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; ctrl_d.reg_write = 1'b1; imm32 = imm_u;
        ctrl_d.alu_src1 = ALUSRC1_PC; ctrl_d.alu_src2 = ALUSRC2_IMM;
      end
      OPC_JAL: begin
        use_rd = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; imm32 = imm_j;
        ctrl_d.alu_src1 = ALUSRC1_PC; ctrl_d.alu_src2 = ALUSRC2_FOUR;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1; imm32 = imm_i;
        ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.jalr = 1'b1;
        ctrl_d.alu_src1 = ALUSRC1_PC; ctrl_d.alu_src2 = ALUSRC2_FOUR;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl_d.branch = 1'b1; imm32 = imm_b;
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1; imm32 = imm_i;
        ctrl_d.reg_write = 1'b1; ctrl_d.mem_read = 1'b1;
        ctrl_d.wb_src = WBSRC_MEM; ctrl_d.alu_src2 = ALUSRC2_IMM;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s;
        ctrl_d.mem_write = 1'b1; ctrl_d.alu_src2 = ALUSRC2_IMM;
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; imm32 = imm_i;
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src2 = ALUSRC2_IMM;
        ctrl_d.alu_op    = funct3;
        // Only SRAI/SRLI carry a real bit 30; for other funct3 it is immediate data.
        ctrl_d.alu_op_alt = (funct3 == 3'b101) && instr[30];
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          ctrl_d.illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          ctrl_d.illegal = 1'b1;
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = funct3;
        if (funct7 == 7'b0000000) begin
          ctrl_d.alu_op_alt = 1'b0;
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl_d.alu_op_alt = 1'b1;
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          ctrl_d.mul_div = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        ctrl_d.env_call  = (instr[31:7] == 25'h0000000);
        ctrl_d.env_break = (instr[31:20] == 12'h001) && (instr[19:7] == 13'h0000);
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    if (REG_ADDR_WIDTH == 4 &&
        ((use_rs1 && instr[19]) || (use_rs2 && instr[24]) || (use_rd && instr[11])))
      ctrl_d.illegal = 1'b1;
    if (ctrl_d.illegal) begin
      ctrl_d.reg_write = 1'b0;
      ctrl_d.mem_write = 1'b0;
    end
  end

  // Load-use: the held load's rd is read by the waiting instruction.
  assign hz = valid_q && ctrl_q.mem_read && (rd_q != '0) && bus.i_Valid &&
              ((use_rs1 && instr[19:15] == 5'(rd_q)) ||
               (use_rs2 && instr[24:20] == 5'(rd_q)));
  assign adv    = !valid_q || bus.i_Ready;
  assign accept = bus.i_Valid && bus.o_Ready;
  assign bus.o_Ready = i_Reset_n && adv && !hz && !bus.i_Flush;

  // NOTE: state uses non-blocking assignments; the bundle registers are reset
  // too because downstream reads them as outputs, not only under o_Valid.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      ctrl_q   <= '0;
    end else begin
      if (bus.i_Flush)
        valid_q <= 1'b0;
      else if (adv)
        valid_q <= accept;
      if (accept) begin
        pc_q     <= bus.i_PC;
        imm_q    <= XLEN'($signed(imm32));
        rs1_q    <= instr[15 +: REG_ADDR_WIDTH];
        rs2_q    <= instr[20 +: REG_ADDR_WIDTH];
        rd_q     <= instr[7 +: REG_ADDR_WIDTH];
        funct3_q <= funct3;
        ctrl_q   <= ctrl_d;
      end
    end
  end

  assign bus.o_Valid              = valid_q;
  assign bus.o_PC                 = pc_q;
  assign bus.o_rs1                = rs1_q;
  assign bus.o_rs2                = rs2_q;
  assign bus.o_rd                 = rd_q;
  assign bus.o_Function           = funct3_q;
  assign bus.o_AluOp              = ctrl_q.alu_op;
  assign bus.o_AluOpAlt           = ctrl_q.alu_op_alt;
  assign bus.o_AluSrc1            = ctrl_q.alu_src1;
  assign bus.o_AluSrc2            = ctrl_q.alu_src2;
  assign bus.o_WritebackSrc       = ctrl_q.wb_src;
  assign bus.o_RegWrite           = ctrl_q.reg_write;
  assign bus.o_MemRead            = ctrl_q.mem_read;
  assign bus.o_MemWrite           = ctrl_q.mem_write;
  assign bus.o_Jump               = ctrl_q.jump;
  assign bus.o_Branch             = ctrl_q.branch;
  assign bus.o_JALR               = ctrl_q.jalr;
  assign bus.o_MulDiv             = ctrl_q.mul_div;
  assign bus.o_EnvCall            = ctrl_q.env_call;
  assign bus.o_EnvBreak           = ctrl_q.env_break;
  assign bus.o_IllegalInstruction = ctrl_q.illegal;
  assign bus.o_Immediate          = imm_q;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage between fetch and execute.
- Accepts one instruction word plus its PC over a valid/ready handshake and decodes it to the existing control-signal set (ALUSRC*, WBSRC*, ALUOP* encodings from the existing headers).
- Presents the decoded bundle from an output register.
- Beyond plain decode it adds:
  - back-pressure handling;
  - a load-use interlock that inserts one bubble;
  - synchronous flush;
  - optional M-extension decode;
  - optional RV32E register-range checking;
  - strict funct7 legality checks.

Parameters:
- XLEN, 32: width of PC and immediate outputs; immediates are sign-extended to XLEN.
- REG_ADDR_WIDTH, 5: 5 = RV32I, 4 = RV32E; register fields are truncated to this width on output.
- ENABLE_M, 0: 1 = decode OP with funct7=0000001 as mul/div; 0 = such encodings are illegal.

Ports:
- i_Clock  in  1  clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_Valid  in  1  fetch presents an instruction
- o_Ready  out  1  stage accepts the instruction this cycle
- i_InstructionWord  in  32  instruction
- i_PC  in  XLEN  instruction address
- i_Flush  in  1  discard held and incoming instruction
- o_Valid  out  1  decoded bundle valid
- i_Ready  in  1  execute accepts the bundle
- o_PC  out  XLEN  registered PC
- o_rs1, o_rs2, o_rd  out  REG_ADDR_WIDTH each  register fields
- o_Function  out  3  funct3
- o_AluOp  out  3; o_AluOpAlt  out  1
- o_AluSrc1, o_AluSrc2  out  2 each
- o_WritebackSrc  out  1
- o_RegWrite, o_MemRead, o_MemWrite, o_Jump, o_Branch, o_JALR, o_MulDiv, o_EnvCall, o_EnvBreak, o_IllegalInstruction  out  1 each
- o_Immediate  out  XLEN

Behaviour:
- Reset: all outputs registered. While i_Reset_n=0 every output register is 0, including o_Valid. o_Ready is combinational and is 0 during reset.
- Latency: 1 cycle from input handshake (i_Valid & o_Ready) to o_Valid.
- Advance condition: adv = !o_Valid | i_Ready.
- Hazard: hz = o_Valid & o_MemRead & (o_rd != 0) & i_Valid, AND the incoming instruction reads o_rd through a used source.
  - rs1 is used by OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
- Handshake: o_Ready = adv & !hz & !i_Flush.
- Output register update when adv:
  - i_Flush → o_Valid=0;
  - else hz → o_Valid=0 (one bubble; the instruction stays on the input);
  - else i_Valid → load decoded bundle, o_Valid=1;
  - else o_Valid=0.
- When !adv: all outputs hold, except i_Flush, which forces o_Valid=0 regardless of adv.
- Stability: while o_Valid & !i_Ready, every output is stable.
- Decode defaults and opcode handling are as the current decoder, with these changes:
  - JALR: o_Immediate = I-type immediate (not J-type).
  - OP_IMM: AluOpAlt = bit30 only for the shift-right funct3.
  - SYSTEM: o_EnvCall/o_EnvBreak are explicitly 0 for all other opcodes and for SYSTEM encodings other than ECALL (0x000) and EBREAK (0x001).
- o_IllegalInstruction=1 (other control bits still decoded, o_RegWrite/o_MemWrite forced 0) when any of:
  - bits[1:0] != 11;
  - unknown opcode;
  - OP with funct7 not 0000000, not 0100000-with-funct3 000/101, and not (0000001 with ENABLE_M=1);
  - OP_IMM shift with illegal funct7;
  - REG_ADDR_WIDTH=4 and bit 4 set in any used rs1/rs2/rd field.
- Mul/div: o_MulDiv=1 only for a legal M encoding; o_Function carries funct3.
- Flush: i_Flush during reset release or mid-stall clears state in 1 cycle; a subsequent instruction decodes normally.

Test Plan:
- ADDI x1,x0,5 (0x00500093), i_Ready=1 → next cycle o_Valid=1, o_RegWrite=1, o_rd=1, o_Immediate=5, o_AluSrc2=ALUSRC2_IMM, o_AluOpAlt=0.
- LW x2,0(x1) (0x0000A103) then ADD x3,x2,x2 (0x002101B3) back-to-back → LW valid, then one o_Valid=0 bubble with o_Ready=0, then ADD valid; same pair with ADD using rd=x0 load (LW x0) → no bubble.
- ADDI followed by i_Ready=0 for 3 cycles → o_Ready=0, all outputs identical across the 3 cycles, next instruction appears 1 cycle after i_Ready returns.
- MUL x5,x6,x7 (0x027302B3): ENABLE_M=1 → o_MulDiv=1, o_IllegalInstruction=0; ENABLE_M=0 → o_IllegalInstruction=1, o_RegWrite=0.
- REG_ADDR_WIDTH=4, add x16,x0,x0 (0x00000833) → o_IllegalInstruction=1; 0x00000000 → illegal in any configuration.
- Flush and reset:
  - i_Flush pulsed while holding a stalled bundle → o_Valid=0 next cycle, incoming word not accepted.
  - i_Reset_n dropped mid-stream → all outputs 0 asynchronously, o_Valid=0 until the first post-reset handshake.
